// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe datapath: cell and winner
// codes, FSM state encodings, the winning-line table and small mux/index helpers.
package tictactoe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        X     = 2'b10,
        O     = 2'b11
    } cellStateType;

    typedef enum logic [1:0] {
        NOWIN = 2'b00,
        TIE   = 2'b01,
        P2WIN = 2'b10,
        P1WIN = 2'b11
    } winnerType;

    localparam logic [3:0] NO_WRITE_ADDR = 4'hF;
    localparam logic [3:0] LAST_CELL     = 4'd8;
    localparam logic [3:0] FULL_BOARD    = 4'd9;
    localparam logic [2:0] LAST_LINE     = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Rows, then columns, then diagonal and anti-diagonal; scan order matters.
    localparam logic [3:0] LINE_TBL [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic [1:0] cell_at(input logic [17:0] board, input logic [3:0] idx);
        return board[{idx, 1'b0} +: 2];
    endfunction

    function automatic logic [1:0] mux2_st(input logic [1:0] d0, input logic [1:0] d1, input logic sel);
        return sel ? d1 : d0;
    endfunction

    function automatic logic [2:0] mux2_k(input logic [2:0] d0, input logic [2:0] d1, input logic sel);
        return sel ? d1 : d0;
    endfunction

endpackage

// File: rtl/game_board_line_check.sv
// Combinational three-in-a-row detector: a line wins when all three cells
// hold the same non-EMPTY code, and that code is reported alongside.
module line_check
    import tictactoe_pkg::*;
(
    input  logic [1:0] cell_a_i,
    input  logic [1:0] cell_b_i,
    input  logic [1:0] cell_c_i,
    output logic       win_o,
    output logic [1:0] code_o
);

    assign win_o  = (cell_a_i == cell_b_i) && (cell_b_i == cell_c_i) && (cell_a_i != EMPTY);
    assign code_o = cell_a_i;

endmodule

// File: rtl/game_board.sv
// Tic-tac-toe board memory and sequential win detector (one line per cycle).
// Optional feature macro: GAME_BOARD_OVERWRITE_PROTECT_EN rejects writes to occupied cells.
module game_board
    import tictactoe_pkg::*;
(
    input  logic        ph1,
    input  logic        ph2,
    input  logic        reset,
    input  logic [3:0]  addr,
    input  logic [1:0]  cellState,
    output logic [17:0] gBoard,
    output logic        gameIsDone,
    output logic [1:0]  winner,
    output logic        busy,
    output logic        writeAck,
    output logic        writeErr,
    output logic [3:0]  moveCount
);

    logic        clk_s;
    logic [1:0]  state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic [17:0] board_q, board_d;
    logic [3:0]  moves_q, moves_d;
    logic        done_q, done_d;
    logic [1:0]  winner_q, winner_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [1:0]  old_cell_s;
    logic        protect_s;
    logic        line_win_s;
    logic [1:0]  line_code_s;

    // ph1 qualified by ~ph2 so an accidental phase overlap cannot clock the state.
    assign clk_s = ph1 & ~ph2;

    assign old_cell_s = cell_at(board_q, addr);

`ifdef GAME_BOARD_OVERWRITE_PROTECT_EN
    assign protect_s = (old_cell_s != EMPTY);
`else
    assign protect_s = 1'b0;
`endif

    line_check u_line_check (
        .cell_a_i (cell_at(board_q, LINE_TBL[k_q][0])),
        .cell_b_i (cell_at(board_q, LINE_TBL[k_q][1])),
        .cell_c_i (cell_at(board_q, LINE_TBL[k_q][2])),
        .win_o    (line_win_s),
        .code_o   (line_code_s)
    );

    // Next-state logic: write acceptance in IDLE, one line per cycle in SCAN.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        board_d  = board_q;
        moves_d  = moves_q;
        done_d   = done_q;
        winner_d = winner_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (addr == NO_WRITE_ADDR) begin
                    err_d = 1'b0;
                end else if ((addr > LAST_CELL) || (cellState == EMPTY) || protect_s) begin
                    err_d = 1'b1;
                end else begin
                    board_d[{addr, 1'b0} +: 2] = cellState;
                    ack_d   = 1'b1;
                    state_d = ST_SCAN;
                    k_d     = 3'd0;
                    if (old_cell_s == EMPTY) begin
                        moves_d = moves_q + 4'd1;
                    end else begin
                        moves_d = moves_q;
                    end
                end
            end
            ST_SCAN: begin
                err_d = (addr != NO_WRITE_ADDR);
                if (line_win_s) begin
                    winner_d = line_code_s;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else if (k_q == LAST_LINE) begin
                    if (moves_q == FULL_BOARD) begin
                        winner_d = TIE;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            ST_DONE: begin
                err_d = (addr != NO_WRITE_ADDR);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_SCAN);
    end

    // State registers with synchronous reset; reset discards any scan in flight.
    always_ff @(posedge clk_s) begin
        state_q <= mux2_st(state_d, ST_IDLE, reset);
        k_q     <= mux2_k(k_d, 3'd0, reset);
        if (reset) begin
            board_q  <= 18'd0;
            moves_q  <= 4'd0;
            done_q   <= 1'b0;
            winner_q <= NOWIN;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            board_q  <= board_d;
            moves_q  <= moves_d;
            done_q   <= done_d;
            winner_q <= winner_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    assign gBoard     = board_q;
    assign gameIsDone = done_q;
    assign winner     = winner_q;
    assign busy       = busy_q;
    assign writeAck   = ack_q;
    assign writeErr   = err_q;
    assign moveCount  = moves_q;

endmodule

// File: tb/tb_game_board.sv
// Directed bench for game_board: writes, errors, win, tie, overwrite, reset mid-scan.
module tb_game_board;

    logic        ph1, ph2, reset;
    logic [3:0]  addr;
    logic [1:0]  cellState;
    logic [17:0] gBoard;
    logic        gameIsDone, busy, writeAck, writeErr;
    logic [1:0]  winner;
    logic [3:0]  moveCount;

    int checks = 0;
    int errors = 0;

    game_board dut (
        .ph1        (ph1),
        .ph2        (ph2),
        .reset      (reset),
        .addr       (addr),
        .cellState  (cellState),
        .gBoard     (gBoard),
        .gameIsDone (gameIsDone),
        .winner     (winner),
        .busy       (busy),
        .writeAck   (writeAck),
        .writeErr   (writeErr),
        .moveCount  (moveCount)
    );

    // Non-overlapping two-phase clock, 10-unit period.
    initial begin
        ph1 = 1'b0;
        ph2 = 1'b0;
        forever begin
            #1 ph1 = 1'b1;
            #4 ph1 = 1'b0;
            #1 ph2 = 1'b1;
            #3 ph2 = 1'b0;
            #1;
        end
    end

    task automatic tick();
        @(posedge ph2);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_board"},  32'(gBoard),     32'h0);
        chk({tag, "_done"},   32'(gameIsDone), 32'h0);
        chk({tag, "_winner"}, 32'(winner),     32'h0);
        chk({tag, "_busy"},   32'(busy),       32'h0);
        chk({tag, "_ack"},    32'(writeAck),   32'h0);
        chk({tag, "_err"},    32'(writeErr),   32'h0);
        chk({tag, "_moves"},  32'(moveCount),  32'h0);
    endtask

    // Present a write for one cycle; returns in the following cycle.
    task automatic wr(input logic [3:0] a, input logic [1:0] c);
        addr = a;
        cellState = c;
        tick();
        addr = 4'hF;
        cellState = 2'b00;
    endtask

    task automatic wait8();
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [1:0] tie_cells [9];

    initial begin
        tie_cells = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10};
        reset = 1'b1;
        addr = 4'hF;
        cellState = 2'b00;
        tick();
        tick();
        chk_zero("reset");
        reset = 1'b0;
        tick();

        // First move: O in the centre
        wr(4'd4, 2'b11);
        chk("t1_ack",   32'(writeAck),  32'h1);
        chk("t1_board", 32'(gBoard),    32'h00300);
        chk("t1_moves", 32'(moveCount), 32'h1);
        chk("t1_busy",  32'(busy),      32'h1);
        tick();
        chk("t1_ack_pulse", 32'(writeAck), 32'h0);
        tick();
        addr = 4'd0;
        cellState = 2'b10;
        tick();
        addr = 4'hF;
        cellState = 2'b00;
        chk("busy_err",       32'(writeErr), 32'h1);
        chk("busy_err_board", 32'(gBoard),   32'h00300);
        chk("busy_err_ack",   32'(writeAck), 32'h0);
        tick();
        chk("err_pulse", 32'(writeErr), 32'h0);
        tick();
        tick();
        tick();
        chk("t1_busy_n8", 32'(busy), 32'h1);
        tick();
        chk("t1_busy_n9", 32'(busy),       32'h0);
        chk("t1_done_n9", 32'(gameIsDone), 32'h0);
        chk("t1_win_n9",  32'(winner),     32'h0);

        // Invalid address and EMPTY write while idle
        addr = 4'd10;
        cellState = 2'b11;
        tick();
        addr = 4'hF;
        cellState = 2'b00;
        chk("bad_addr_err",   32'(writeErr), 32'h1);
        chk("bad_addr_ack",   32'(writeAck), 32'h0);
        chk("bad_addr_board", 32'(gBoard),   32'h00300);
        addr = 4'd3;
        tick();
        addr = 4'hF;
        chk("empty_err",   32'(writeErr),  32'h1);
        chk("empty_board", 32'(gBoard),    32'h00300);
        chk("empty_moves", 32'(moveCount), 32'h1);

        // Row 0 win for O
        wr(4'd0, 2'b11);
        chk("t2_board0", 32'(gBoard),    32'h00303);
        chk("t2_moves0", 32'(moveCount), 32'h2);
        wait8();
        wr(4'd1, 2'b11);
        chk("t2_board1", 32'(gBoard), 32'h0030F);
        wait8();
        wr(4'd2, 2'b11);
        chk("t2_busy_n1", 32'(busy),       32'h1);
        chk("t2_done_n1", 32'(gameIsDone), 32'h0);
        tick();
        chk("t2_winner", 32'(winner),     32'h3);
        chk("t2_done",   32'(gameIsDone), 32'h1);
        chk("t2_busy",   32'(busy),       32'h0);
        chk("t2_board",  32'(gBoard),     32'h0033F);
        chk("t2_moves",  32'(moveCount),  32'h4);

        // Write after DONE is rejected; everything stays frozen
        addr = 4'd5;
        cellState = 2'b10;
        tick();
        addr = 4'hF;
        cellState = 2'b00;
        chk("done_err",    32'(writeErr),   32'h1);
        chk("done_ack",    32'(writeAck),   32'h0);
        chk("done_board",  32'(gBoard),     32'h0033F);
        chk("done_winner", 32'(winner),     32'h3);
        chk("done_flag",   32'(gameIsDone), 32'h1);

        do_reset();
        chk_zero("rst_done");

        // Reset in cycle N+4 of a scan
        wr(4'd0, 2'b10);
        tick();
        tick();
        tick();
        do_reset();
        chk_zero("rst_scan");
        wr(4'd8, 2'b11);
        chk("post_rst_ack",   32'(writeAck),  32'h1);
        chk("post_rst_board", 32'(gBoard),    32'h30000);
        chk("post_rst_moves", 32'(moveCount), 32'h1);
        wait8();
        chk("post_rst_idle", 32'(busy), 32'h0);

        // Overwrite of occupied cell 4
        do_reset();
        wr(4'd4, 2'b11);
        wait8();
        wr(4'd4, 2'b10);
`ifdef GAME_BOARD_OVERWRITE_PROTECT_EN
        chk("ow_err",   32'(writeErr),  32'h1);
        chk("ow_ack",   32'(writeAck),  32'h0);
        chk("ow_board", 32'(gBoard),    32'h00300);
        chk("ow_busy",  32'(busy),      32'h0);
`else
        chk("ow_err",   32'(writeErr),  32'h0);
        chk("ow_ack",   32'(writeAck),  32'h1);
        chk("ow_board", 32'(gBoard),    32'h00200);
        chk("ow_busy",  32'(busy),      32'h1);
`endif
        chk("ow_moves", 32'(moveCount), 32'h1);
        wait8();

        // Full board with no line: X O X / X O O / O X X
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr(4'(i), tie_cells[i]);
            wait8();
        end
        chk("tie_pre_done", 32'(gameIsDone), 32'h0);
        wr(4'd8, tie_cells[8]);
        chk("tie_moves",   32'(moveCount), 32'h9);
        chk("tie_busy_n1", 32'(busy),      32'h1);
        for (int i = 0; i < 7; i++) tick();
        chk("tie_busy_n8", 32'(busy),       32'h1);
        chk("tie_done_n8", 32'(gameIsDone), 32'h0);
        tick();
        chk("tie_winner", 32'(winner),     32'h1);
        chk("tie_done",   32'(gameIsDone), 32'h1);
        chk("tie_busy",   32'(busy),       32'h0);
        chk("tie_board",  32'(gBoard),     32'h2BFAE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_board.md
# game_board

Board memory and win detector for the tic-tac-toe datapath, sitting on the receiving end of the game controller's cell-write interface. It accepts one cell write per move (cell address plus cell state), stores the nine-cell board, and after every accepted write runs an 8-cycle sequential scan of all winning lines. It then reports the board image, game-done flag and winner code back to the controller.

## Interface
Parameters:
- none

Ports:
- ph1, ph2  in  1  two-phase non-overlapping clock pair; this is the block's one clock, and all state is held in flop (ph1/ph2) registers
- reset  in  1  synchronous, active-high
- addr  in  4  cell address; 0..8 row-major, 15 = no write, 9..14 invalid
- cellState  in  2  cellStateType to write: EMPTY=00, O=11 (player1), X=10 (player2)
- gBoard  out  18  board image; cell i occupies bits [2i+1:2i]
- gameIsDone  out  1  sticky; game over (win or tie)
- winner  out  2  11 = player1, 10 = player2, 01 = tie, 00 = no win
- busy  out  1  scan in progress; writes are not accepted
- writeAck  out  1  one-cycle pulse when a write is accepted
- writeErr  out  1  one-cycle pulse when a write is rejected
- moveCount  out  4  number of cells changed from EMPTY to occupied (0..9)

## Operation
- FSM states:
  - IDLE: accepts writes
  - SCAN: line index k counts 0..7
  - DONE: terminal
- Reset values: gBoard=0, gameIsDone=0, winner=00, busy=0, writeAck=0, writeErr=0, moveCount=0, state IDLE, k=0.
- Write handling in IDLE:
  - addr=15: no-op, no pulse.
  - addr 9..14, or cellState=EMPTY: writeErr, board unchanged.
  - Otherwise the write is accepted: cell is updated, writeAck pulses, next state is SCAN with k=0.
  - moveCount increments only when the target cell was EMPTY.
- Writes presented in SCAN or DONE (addr≠15) are dropped and pulse writeErr.
- Line order for k:
  - 0..2: rows {0,1,2}, {3,4,5}, {6,7,8}
  - 3..5: columns {0,3,6}, {1,4,7}, {2,5,8}
  - 6: diagonal {0,4,8}
  - 7: anti-diagonal {2,4,6}
- A line wins when all three cells are equal and non-EMPTY.
- SCAN transitions:
  - Line k wins: winner = that cell's code (11 or 10), gameIsDone=1, go to DONE. This is an early exit; the first winning line in k order decides.
  - k=7, no win, moveCount=9: winner=01, gameIsDone=1, go to DONE.
  - k=7, no win, moveCount<9: go to IDLE.
  - Otherwise k increments.
- DONE holds until reset. gBoard, winner and gameIsDone stay frozen.
- A win on the ninth move reports the player, not a tie.
- Reset mid-scan: the block returns to IDLE with an empty board on the next edge, and the partial scan is discarded.

## Timing
- A write accepted in cycle N:
  - gBoard and moveCount updated, and busy=1, from cycle N+1.
  - writeAck is high in cycle N+1.
- Line k is evaluated in cycle N+1+k.
- A win on line k makes gameIsDone/winner visible in cycle N+2+k, with busy low from the same cycle.
- No win: busy is low and the result (tie or continue) is visible in cycle N+9.
- Minimum accepted-write spacing is 9 cycles; a write in cycle N+9 is accepted.
- writeErr for a rejected write presented in cycle N is high in cycle N+1.
- Reset asserted in cycle N: all outputs are at their reset values in cycle N+1.

## Configuration
- GAME_BOARD_OVERWRITE_PROTECT_EN
  - Defined: a write to a non-EMPTY cell is rejected with writeErr, and the board and moveCount are unchanged.
  - Undefined: the write is accepted and overwrites the cell (writeAck, scan runs), and moveCount is not incremented.

## Structure
- Shared package (tictactoe_pkg):
  - cellStateType enum (EMPTY/O/X)
  - winner codes as a typedef: NOWIN=00, TIE=01, P2WIN=10, P1WIN=11
  - NO_WRITE_ADDR=4'hF constant
  - 8×3 winning-line cell-index table constant
- Sub-module line_check: combinational; inputs are three 2-bit cells, outputs are win and the cell code. Instantiated once and fed by a mux driven by the k-indexed line table.
- The FSM state and k register use mux2 reset muxes plus flop, as in the rest of the datapath.

## Test plan
- Reset, then write addr=4, cellState=11 -> writeAck in N+1; gBoard=18'h00300; moveCount=1; busy high N+1..N+8; gameIsDone=0 in N+9.
- O at 0, 1, 2 (each 9 cycles apart) -> the third scan hits k=0 at N+1; winner=11 and gameIsDone=1 in cycle N+2.
- Fill nine cells with no line (X O X / X O O / O X X) -> in N+9 after the last write: winner=01, gameIsDone=1, moveCount=9.
- Write during busy (cycle N+3) and write addr=10 in IDLE -> both pulse writeErr one cycle later, and gBoard is unchanged.
- Write to occupied cell 4 -> with the macro: writeErr, cell remains 11. Without it: cell becomes 10, writeAck pulses, moveCount unchanged.
- Assert reset at cycle N+4 of a scan; write after DONE -> all outputs return to zero; a post-DONE write gives writeErr and the frozen board.
